// File: rtl/obstacle_pacer.sv
// Scroll pacing for the obstacle generator: emits a one-cycle scroll pulse every
// period_out cycles while running, with an LFSR-driven placement bit and a speed ramp.
module obstacle_pacer #(
  parameter int          PERIOD_INIT = 1000,
  parameter int          PERIOD_MIN  = 250,
  parameter int          PERIOD_STEP = 50,
  parameter int          RAMP_TICKS  = 64,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        halt,
  input  logic [7:0]  density,
  output logic        scroll_en,
  output logic        rng_out,
  output logic [15:0] period_out,
  output logic [3:0]  level
);

  localparam logic [15:0] P_INIT    = 16'(PERIOD_INIT);
  localparam logic [15:0] P_MIN     = 16'(PERIOD_MIN);
  localparam logic [15:0] P_STEP    = 16'(PERIOD_STEP);
  localparam logic [15:0] RAMP_LAST = 16'(RAMP_TICKS - 1);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state;
  logic [15:0] divider;
  logic [15:0] ramp_cnt;
  logic [15:0] lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    if (v == 16'd0) return LFSR_SEED;
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'd0);
  endfunction

  // Widened compare so PERIOD_MIN + PERIOD_STEP cannot wrap.
  function automatic logic [15:0] ramp_period(input logic [15:0] p);
    if ({1'b0, p} < ({1'b0, P_MIN} + {1'b0, P_STEP})) return P_MIN;
    return p - P_STEP;
  endfunction

  function automatic logic [3:0] sat_level(input logic [3:0] l);
    return (l == 4'd15) ? 4'd15 : l + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      scroll_en  <= 1'b0;
      rng_out    <= 1'b0;
      period_out <= P_INIT;
      level      <= 4'd0;
      divider    <= 16'd0;
      ramp_cnt   <= 16'd0;
      lfsr       <= LFSR_SEED;
    end else begin
      lfsr      <= lfsr_step(lfsr);
      scroll_en <= 1'b0;
      case (state)
        IDLE: begin
          divider    <= 16'd0;
          ramp_cnt   <= 16'd0;
          level      <= 4'd0;
          period_out <= P_INIT;
          if (run) state <= RUN;
        end
        RUN: begin
          if (halt) begin
            state <= HALT;
          end else if (!run) begin
            // Restart values are loaded on the way out so IDLE never shows stale ones.
            state      <= IDLE;
            divider    <= 16'd0;
            ramp_cnt   <= 16'd0;
            level      <= 4'd0;
            period_out <= P_INIT;
          end else if (divider == period_out - 16'd1) begin
            divider   <= 16'd0;
            scroll_en <= 1'b1;
            rng_out   <= (lfsr[7:0] < density);
            if (ramp_cnt == RAMP_LAST) begin
              ramp_cnt   <= 16'd0;
              period_out <= ramp_period(period_out);
              level      <= sat_level(level);
            end else begin
              ramp_cnt <= ramp_cnt + 16'd1;
            end
          end else begin
            divider <= divider + 16'd1;
          end
        end
        HALT: begin
          if (!run) begin
            state      <= IDLE;
            divider    <= 16'd0;
            ramp_cnt   <= 16'd0;
            level      <= 4'd0;
            period_out <= P_INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/obstacle_pacer.md
# obstacle_pacer

Upstream pacing stage for the obstacle generator. Produces the one-cycle scroll enable pulse that advances the obstacle field and the per-step random placement bit consumed with it. Internally a free-running 16-bit LFSR, a programmable clock divider, and a speed ramp that shortens the scroll period as the game progresses. A three-state run controller (IDLE/RUN/HALT) is driven by game control.

## Interface
Parameters:
- PERIOD_INIT, 1000: clock cycles per scroll step at game start (≥ PERIOD_MIN).
- PERIOD_MIN, 250: fastest allowed period (≥ 2).
- PERIOD_STEP, 50: period decrement per ramp event.
- RAMP_TICKS, 64: scroll pulses between ramp events (≥ 1, ≤ 65535).
- LFSR_SEED, 16'hACE1: LFSR reset value (nonzero).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  game running request (level).
- halt  in  1  collision/freeze request (level, sampled in RUN only).
- density  in  8  placement threshold; higher means more obstacles.
- scroll_en  out  1  one-cycle scroll pulse to the obstacle generator's enable.
- rng_out  out  1  placement bit to the obstacle generator's RNG input; valid with scroll_en.
- period_out  out  16  current scroll period in cycles.
- level  out  4  ramp events since start, saturating at 15.

## Operation
- Reset (rst high at an edge): state IDLE, scroll_en 0, rng_out 0, period_out PERIOD_INIT, level 0, divider 0, ramp counter 0, LFSR LFSR_SEED. Reset overrides all other inputs.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Shift right each clock in every state; if the LSB shifted out is 1, XOR with the mask. If the register ever reads 0, reload LFSR_SEED. Period 65535.
- IDLE: no pulses. Divider, ramp counter, and level held at 0; period_out PERIOD_INIT. When run=1, go to RUN.
- RUN: divider counts 0..period_out−1. On the edge where divider == period_out−1:
  - divider ← 0, scroll_en ← 1 for one cycle.
  - rng_out ← (lfsr[7:0] < density), using the pre-edge LFSR value.
  - ramp counter increments.
- Ramp: on the pulse edge where ramp counter == RAMP_TICKS−1, ramp counter ← 0. Period_out ← max(period_out − PERIOD_STEP, PERIOD_MIN), computed without underflow (if period_out < PERIOD_MIN + PERIOD_STEP, load PERIOD_MIN). Level ← min(level+1, 15). The new period governs the next interval.
- RUN with halt=1 goes to HALT. Halt has priority over a due pulse: no pulse, and rng_out is held.
- RUN with run=0 (and halt=0) goes to IDLE with no pulse.
- HALT: no pulses; divider, period_out, level, and rng_out frozen. run=0 goes to IDLE; halt is ignored while in HALT. Leaving IDLE always restarts from PERIOD_INIT/level 0.
- rng_out holds its last value between pulses. It returns to 0 only on reset.
- density=0 gives rng_out always 0. density=255 gives 0 only when lfsr[7:0]==255.

## Timing
- All outputs are registered.
- If the state register first reads RUN in cycle T, divider=0 in T. The first scroll_en is high in cycle T+period_out, then every period_out cycles.
- scroll_en is never high on two consecutive cycles.
- IDLE→RUN takes 1 cycle after run is sampled high. Pulse spacing restarts from zero on every entry.
- Ramp update to period_out and level is visible in the same cycle scroll_en is high.
- rst mid-operation: outputs hold reset values from the cycle after the reset edge. A pulse due on that edge is suppressed.

## Test plan
Bench parameters: PERIOD_INIT=8, PERIOD_MIN=4, PERIOD_STEP=3, RAMP_TICKS=4, LFSR_SEED=16'hACE1.
- Reset, then run=1, halt=0, density=255 with state RUN at cycle T: scroll_en high exactly at T+8, T+16, T+24, T+32. period_out=8 until the 4th pulse.
- Continue running: at the 4th pulse, period_out=5 and level=1; next pulse 5 cycles later. At the 8th pulse, period_out=4 (saturated, no underflow) and level=2. At the 12th pulse, period_out=4 and level=3. Drive 80 pulses: level saturates at 15.
- Density sweep: density=0 gives rng_out=0 at every pulse. Density=128 gives rng_out equal to the model's (lfsr[7:0]<128) at each pulse. The LFSR matches a reference model from 16'hACE1 for 65535 cycles and returns to seed.
- halt=1 asserted on the cycle a pulse is due: no pulse, state HALT, period_out, level, and rng_out unchanged for 20 cycles. Then run=0 gives IDLE and period_out=8, level=0. run=1 again gives the first pulse 8 cycles after RUN entry.
- run dropped mid-interval: no further pulses. Re-raise run 3 cycles later: spacing restarts (first pulse 8 cycles after RUN entry).
- rst pulsed 1 cycle while divider==7 (pulse due): no pulse. Next cycle scroll_en=0, rng_out=0, period_out=8, level=0, state IDLE, LFSR=16'hACE1.
